// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: op classes, operation codes,
// the mult/div sequencer states and the divide-by-zero quotient fill.
// Optional feature macro: EX_FAST_MUL_EN (single-cycle multiplier).
package ex_pkg;

  // Operation class presented on alusel_i
  typedef enum logic [2:0] {
    SEL_NOP    = 3'd0,
    SEL_LOGIC  = 3'd1,
    SEL_SHIFT  = 3'd2,
    SEL_ARITH  = 3'd3,
    SEL_MOVE   = 3'd4,
    SEL_MULDIV = 3'd5
  } alusel_e;

  // Operation codes presented on aluop_i
  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h20;
  localparam logic [7:0] OP_ADDU  = 8'h21;
  localparam logic [7:0] OP_SUB   = 8'h22;
  localparam logic [7:0] OP_SUBU  = 8'h23;
  localparam logic [7:0] OP_SLT   = 8'h2A;
  localparam logic [7:0] OP_SLTU  = 8'h2B;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;

  // Mult/div sequencer states
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Fill bit replicated across LO when the divisor is zero (all ones)
  localparam logic DIV_BY_ZERO_LO = 1'b1;

  // True for the four operations the iterative unit executes
  function automatic logic is_muldiv_op(input logic [7:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_DIV)  || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative multiply/divide sequencer. Operands are converted to
// magnitudes on start; one shift-add (multiply) or restoring-subtract
// (divide) step runs per BUSY cycle; signs are re-applied to the
// results presented in DONE.
// Handshake: start_i is honoured only in IDLE; abort_i returns BUSY to
// IDLE on the next edge; DONE lasts exactly one cycle and hi_o/lo_o are
// valid throughout it.
// Optional feature macro: EX_FAST_MUL_EN (multiply completes IDLE->DONE).
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              is_div_i,
  input  logic              is_signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output md_state_e         state_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  md_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     opnd_q, opnd_d;
  logic                  is_div_q, is_div_d;
  logic                  neg_res_q, neg_res_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  div0_q, div0_d;

  logic                  a_neg, b_neg;
  logic [DATA_W-1:0]     a_mag, b_mag;
  logic [DATA_W:0]       mul_sum;
  logic [2*DATA_W-1:0]   mul_next;
  logic [DATA_W:0]       div_shift, div_diff;
  logic [2*DATA_W-1:0]   div_next;
  logic [2*DATA_W-1:0]   prod;
  logic [DATA_W-1:0]     quot, rem;

  assign a_neg = is_signed_i & a_i[DATA_W-1];
  assign b_neg = is_signed_i & b_i[DATA_W-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // Multiply step: conditionally add multiplicand to the upper half, shift right
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

  // Divide step: shift next dividend bit into the remainder, trial-subtract
  assign div_shift = acc_q[2*DATA_W-1:DATA_W-1];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[DATA_W]
                   ? {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                   : {div_diff[DATA_W-1:0],  acc_q[DATA_W-2:0], 1'b1};

  // Sign correction of the unsigned results
  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quot = acc_q[DATA_W-1:0];
  assign rem  = acc_q[2*DATA_W-1:DATA_W];

  // Result selection presented to the HI/LO registers during DONE
  always_comb begin
    hi_o = prod[2*DATA_W-1:DATA_W];
    lo_o = prod[DATA_W-1:0];
    if (is_div_q) begin
      hi_o = neg_rem_q ? -rem : rem;
      lo_o = div0_q ? {DATA_W{DIV_BY_ZERO_LO}} : (neg_res_q ? -quot : quot);
    end
  end

  // Next-state, counter and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          is_div_d  = is_div_i;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = is_div_i && (b_i == '0);
          opnd_d    = b_mag;
          acc_d     = {{DATA_W{1'b0}}, a_mag};
          cnt_d     = '0;
          state_d   = MD_BUSY;
`ifdef EX_FAST_MUL_EN
          if (!is_div_i) begin
            acc_d   = {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
            state_d = MD_DONE;
          end
`endif
        end
      end
      MD_BUSY: begin
        if (abort_i) begin
          cnt_d   = '0;
          state_d = MD_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d   = '0;
            state_d = MD_DONE;
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Sequencer state and operand registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/ex_muldiv_stage.sv
// Execute stage: single-cycle ALU (logic, shift, arith, move), HI/LO
// registers, EX/MEM output registers and the mult/div sequencer.
// Handshake: stallreq_o is combinational; while it is high the pipeline
// holds the same instruction on the inputs and the outputs register
// bubbles; the MULDIV op is consumed in the DONE cycle, which does not stall.
// Optional feature macro: EX_FAST_MUL_EN (single-cycle multiply).
module ex_muldiv_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [2:0]        alusel_i,
  input  logic [7:0]        aluop_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              ovf_o,
  output logic              stallreq_o
);

  localparam int SH_W = $clog2(DATA_W);

  md_state_e         md_state;
  logic [DATA_W-1:0] md_hi, md_lo;
  logic              op_live, md_is_op, md_start, md_is_div, md_is_signed;

  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [REG_AW-1:0] wd_q, wd_d;
  logic              wreg_q, wreg_d, ovf_q, ovf_d;

  logic [DATA_W-1:0] add_sum, sub_diff;
  logic              add_ovf, sub_ovf, slt_s, slt_u;
  logic [SH_W-1:0]   sh_amt;
  logic [DATA_W-1:0] res;
  logic              hit, ovf_hit;

  assign op_live      = valid_i && !flush_i;
  assign md_is_op     = op_live && (alusel_i == SEL_MULDIV) && is_muldiv_op(aluop_i);
  assign md_start     = md_is_op && (md_state == MD_IDLE);
  assign md_is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign md_is_signed = (aluop_i == OP_MULT) || (aluop_i == OP_DIV);
  assign stallreq_o   = md_start || ((md_state == MD_BUSY) && !flush_i);

  muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
    .clk         (clk),
    .rst         (rst),
    .start_i     (md_start),
    .abort_i     (flush_i),
    .is_div_i    (md_is_div),
    .is_signed_i (md_is_signed),
    .a_i         (reg1_i),
    .b_i         (reg2_i),
    .state_o     (md_state),
    .hi_o        (md_hi),
    .lo_o        (md_lo)
  );

  assign add_sum  = reg1_i + reg2_i;
  assign sub_diff = reg1_i - reg2_i;
  assign add_ovf  = (reg1_i[DATA_W-1] == reg2_i[DATA_W-1]) &&
                    (add_sum[DATA_W-1] != reg1_i[DATA_W-1]);
  assign sub_ovf  = (reg1_i[DATA_W-1] != reg2_i[DATA_W-1]) &&
                    (sub_diff[DATA_W-1] != reg1_i[DATA_W-1]);
  assign slt_s    = $signed(reg1_i) < $signed(reg2_i);
  assign slt_u    = reg1_i < reg2_i;
  assign sh_amt   = reg1_i[SH_W-1:0];

  // ALU result selection, HI/LO update and next EX/MEM register contents
  always_comb begin
    res     = '0;
    hit     = 1'b0;
    ovf_hit = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    wd_d    = '0;
    wreg_d  = 1'b0;
    wdata_d = '0;
    ovf_d   = 1'b0;
    if (md_state == MD_DONE) begin
      // A squash arriving in the completion cycle discards the result
      if (!flush_i) begin
        hi_d = md_hi;
        lo_d = md_lo;
      end
    end else if (md_state == MD_BUSY) begin
      // Stalled: the held instruction emits bubbles until completion
      hit = 1'b0;
    end else if (op_live) begin
      case (alusel_i)
        SEL_LOGIC: begin
          hit = 1'b1;
          case (aluop_i)
            OP_OR:   res = reg1_i | reg2_i;
            OP_AND:  res = reg1_i & reg2_i;
            OP_XOR:  res = reg1_i ^ reg2_i;
            OP_NOR:  res = ~(reg1_i | reg2_i);
            default: hit = 1'b0;
          endcase
        end
        SEL_SHIFT: begin
          hit = 1'b1;
          case (aluop_i)
            OP_SLL:  res = reg2_i << sh_amt;
            OP_SRL:  res = reg2_i >> sh_amt;
            OP_SRA:  res = $unsigned($signed(reg2_i) >>> sh_amt);
            default: hit = 1'b0;
          endcase
        end
        SEL_ARITH: begin
          hit = 1'b1;
          case (aluop_i)
            OP_ADD: begin
              res     = add_sum;
              ovf_hit = add_ovf;
            end
            OP_ADDU: res = add_sum;
            OP_SUB: begin
              res     = sub_diff;
              ovf_hit = sub_ovf;
            end
            OP_SUBU: res = sub_diff;
            OP_SLT:  res = {{(DATA_W-1){1'b0}}, slt_s};
            OP_SLTU: res = {{(DATA_W-1){1'b0}}, slt_u};
            default: hit = 1'b0;
          endcase
        end
        SEL_MOVE: begin
          case (aluop_i)
            OP_MFHI: begin
              res = hi_q;
              hit = 1'b1;
            end
            OP_MFLO: begin
              res = lo_q;
              hit = 1'b1;
            end
            OP_MTHI: hi_d = reg1_i;
            OP_MTLO: lo_d = reg1_i;
            default: hit = 1'b0;
          endcase
        end
        default: hit = 1'b0;
      endcase
      if (hit) begin
        // Overflow keeps the destination visible for the trap but writes nothing
        wd_d = wd_i;
        if (ovf_hit) begin
          ovf_d = 1'b1;
        end else begin
          wreg_d  = wreg_i;
          wdata_d = res;
        end
      end
    end
  end

  // HI/LO and EX/MEM boundary registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q    <= '0;
      lo_q    <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wd_o    = wd_q;
  assign wreg_o  = wreg_q;
  assign wdata_o = wdata_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Bench for ex_muldiv_stage: directed vectors, expected EX/MEM records
// queued at issue time and popped by a monitor whenever the stage emits
// a non-bubble output. Stall lengths and reset values checked inline.
module tb_ex_muldiv_stage;
  import ex_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int REC_W  = REG_AW + 1 + DATA_W + 1;
`ifdef EX_FAST_MUL_EN
  localparam int         MUL_STALLS = 1;
  localparam logic [7:0] FLUSH_OP   = OP_DIV;
`else
  localparam int         MUL_STALLS = DATA_W + 1;
  localparam logic [7:0] FLUSH_OP   = OP_MULT;
`endif
  localparam int DIV_STALLS = DATA_W + 1;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              valid_i = 1'b0;
  logic              flush_i = 1'b0;
  logic [2:0]        alusel_i = '0;
  logic [7:0]        aluop_i = '0;
  logic [DATA_W-1:0] reg1_i = '0;
  logic [DATA_W-1:0] reg2_i = '0;
  logic [REG_AW-1:0] wd_i = '0;
  logic              wreg_i = 1'b0;
  logic [REG_AW-1:0] wd_o;
  logic              wreg_o;
  logic [DATA_W-1:0] wdata_o;
  logic              ovf_o;
  logic              stallreq_o;

  always #5 clk = ~clk;

  ex_muldiv_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .flush_i    (flush_i),
    .alusel_i   (alusel_i),
    .aluop_i    (aluop_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .ovf_o      (ovf_o),
    .stallreq_o (stallreq_o)
  );

  // ---------------- scoreboard ----------------
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] mon_exp;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [REG_AW-1:0] wd, input logic wreg,
                            input logic [DATA_W-1:0] wdata, input logic ovf);
    exp_q.push_back({wd, wreg, wdata, ovf});
  endtask

  // Monitor: every non-bubble output must match the oldest expectation
  always @(negedge clk) begin
    if (rst && (wreg_o || ovf_o || (wd_o != '0) || (wdata_o != '0))) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got wd=%0d wreg=%0b wdata=0x%08h ovf=%0b, required bubble",
                 wd_o, wreg_o, wdata_o, ovf_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({wd_o, wreg_o, wdata_o, ovf_o} !== mon_exp) begin
          errors++;
          $display("FAIL output: got wd=%0d wreg=%0b wdata=0x%08h ovf=%0b, required wd=%0d wreg=%0b wdata=0x%08h ovf=%0b",
                   wd_o, wreg_o, wdata_o, ovf_o,
                   mon_exp[REC_W-1 -: REG_AW], mon_exp[DATA_W+1], mon_exp[DATA_W:1], mon_exp[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] sel, input logic [7:0] op,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [REG_AW-1:0] wd, input logic wr);
    valid_i = 1'b1; flush_i = 1'b0; alusel_i = sel; aluop_i = op;
    reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0; flush_i = 1'b0; alusel_i = '0; aluop_i = '0;
    reg1_i = '0; reg2_i = '0; wd_i = '0; wreg_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Hold a MULDIV op until the stall drops; optionally flush on BUSY cycle flush_at
  task automatic run_muldiv(input string name, input logic [7:0] op,
                            input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input int exp_stalls, input int flush_at);
    int stalls;
    bit ended;
    stalls = 0;
    ended  = 1'b0;
    valid_i = 1'b1; flush_i = 1'b0; alusel_i = SEL_MULDIV; aluop_i = op;
    reg1_i = a; reg2_i = b; wd_i = '0; wreg_i = 1'b0;
    for (int i = 0; i < 200 && !ended; i++) begin
      if (flush_at > 0 && stalls == flush_at) flush_i = 1'b1;
      @(negedge clk);
      if (flush_i) begin
        check({name, "_stall_drop_on_flush"}, 64'(stallreq_o), 64'd0);
        ended = 1'b1;
      end else if (stallreq_o) begin
        stalls++;
      end else begin
        ended = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ended) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: stall still high after %0d cycles, required release", name, stalls);
    end else if (flush_at > 0) begin
      check({name, "_stalls_before_flush"}, 64'(stalls), 64'(flush_at));
    end else begin
      check({name, "_stall_cycles"}, 64'(stalls), 64'(exp_stalls));
    end
    idle(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle(3);
    check("reset_wd_o", 64'(wd_o), 64'd0);
    check("reset_wreg_o", 64'(wreg_o), 64'd0);
    check("reset_wdata_o", 64'(wdata_o), 64'd0);
    check("reset_ovf_o", 64'(ovf_o), 64'd0);
    rst = 1'b1;
    idle(1);

    // Load HI/LO, then reset in the middle of a DIV
    issue(SEL_MOVE, OP_MTHI, 32'h0000_1234, 32'h0, 5'd0, 1'b0);
    issue(SEL_MOVE, OP_MTLO, 32'h0000_5678, 32'h0, 5'd0, 1'b0);
    valid_i = 1'b1; alusel_i = SEL_MULDIV; aluop_i = OP_DIV;
    reg1_i = 32'd100; reg2_i = 32'd7;
    repeat (6) begin @(posedge clk); #1; end
    check("busy_before_reset_stall", 64'(stallreq_o), 64'd1);
    rst = 1'b0;
    valid_i = 1'b0;
    #1;
    check("midop_reset_stall", 64'(stallreq_o), 64'd0);
    check("midop_reset_outputs", {wd_o, wreg_o, wdata_o, ovf_o}, 64'd0);
    idle(2);
    rst = 1'b1;
    idle(1);
    expect_out(5'd2, 1'b1, 32'h0, 1'b0);
    issue(SEL_MOVE, OP_MFHI, 32'h0, 32'h0, 5'd2, 1'b1);
    expect_out(5'd3, 1'b1, 32'h0, 1'b0);
    issue(SEL_MOVE, OP_MFLO, 32'h0, 32'h0, 5'd3, 1'b1);

    // Arithmetic and overflow
    expect_out(5'd3, 1'b0, 32'h0, 1'b1);
    issue(SEL_ARITH, OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1);
    expect_out(5'd4, 1'b1, 32'h8000_0000, 1'b0);
    issue(SEL_ARITH, OP_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd4, 1'b1);
    expect_out(5'd5, 1'b0, 32'h0, 1'b1);
    issue(SEL_ARITH, OP_SUB, 32'h8000_0000, 32'h1, 5'd5, 1'b1);
    expect_out(5'd6, 1'b1, 32'h7FFF_FFFF, 1'b0);
    issue(SEL_ARITH, OP_SUBU, 32'h8000_0000, 32'h1, 5'd6, 1'b1);
    expect_out(5'd7, 1'b1, 32'h2, 1'b0);
    issue(SEL_ARITH, OP_ADD, 32'h5, 32'hFFFF_FFFD, 5'd7, 1'b1);
    expect_out(5'd8, 1'b1, 32'h1, 1'b0);
    issue(SEL_ARITH, OP_SLT, 32'hFFFF_FFFF, 32'h1, 5'd8, 1'b1);
    expect_out(5'd9, 1'b1, 32'h0, 1'b0);
    issue(SEL_ARITH, OP_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd9, 1'b1);

    // Logic and shift
    expect_out(5'd10, 1'b1, 32'hFFFF_FFFF, 1'b0);
    issue(SEL_LOGIC, OP_NOR, 32'h0, 32'h0, 5'd10, 1'b1);
    expect_out(5'd11, 1'b1, 32'hF0F0_0F0F, 1'b0);
    issue(SEL_LOGIC, OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, 5'd11, 1'b1);
    expect_out(5'd12, 1'b1, 32'h0F00_0F00, 1'b0);
    issue(SEL_LOGIC, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd12, 1'b1);
    expect_out(5'd13, 1'b1, 32'hF0F0_0F0F, 1'b0);
    issue(SEL_LOGIC, OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd13, 1'b1);
    expect_out(5'd14, 1'b1, 32'hF800_0000, 1'b0);
    issue(SEL_SHIFT, OP_SRA, 32'h24, 32'h8000_0000, 5'd14, 1'b1);
    expect_out(5'd15, 1'b1, 32'h0800_0000, 1'b0);
    issue(SEL_SHIFT, OP_SRL, 32'h4, 32'h8000_0000, 5'd15, 1'b1);
    expect_out(5'd16, 1'b1, 32'h8000_0000, 1'b0);
    issue(SEL_SHIFT, OP_SLL, 32'h1F, 32'h1, 5'd16, 1'b1);
    expect_out(5'd17, 1'b0, 32'h3, 1'b0);
    issue(SEL_ARITH, OP_ADDU, 32'h1, 32'h2, 5'd17, 1'b0);

    // Bubbles: none of these may produce an output
    valid_i = 1'b0;
    alusel_i = SEL_ARITH; aluop_i = OP_ADDU; reg1_i = 32'h11; reg2_i = 32'h22;
    wd_i = 5'd18; wreg_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    issue(SEL_NOP, OP_ADDU, 32'h11, 32'h22, 5'd18, 1'b1);
    issue(SEL_LOGIC, 8'hFF, 32'h11, 32'h22, 5'd18, 1'b1);
    valid_i = 1'b1; flush_i = 1'b0; alusel_i = SEL_MULDIV; aluop_i = 8'hFF;
    #1;
    check("unknown_muldiv_no_stall", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    idle(1);

    // Multiply / divide
    run_muldiv("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, MUL_STALLS, 0);
    expect_out(5'd20, 1'b1, 32'hFFFF_FFEB, 1'b0);
    issue(SEL_MOVE, OP_MFLO, 32'h0, 32'h0, 5'd20, 1'b1);
    expect_out(5'd21, 1'b1, 32'hFFFF_FFFF, 1'b0);
    issue(SEL_MOVE, OP_MFHI, 32'h0, 32'h0, 5'd21, 1'b1);

    run_muldiv("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_STALLS, 0);
    expect_out(5'd22, 1'b1, 32'hFFFF_FFFD, 1'b0);
    issue(SEL_MOVE, OP_MFLO, 32'h0, 32'h0, 5'd22, 1'b1);
    expect_out(5'd23, 1'b1, 32'hFFFF_FFFF, 1'b0);
    issue(SEL_MOVE, OP_MFHI, 32'h0, 32'h0, 5'd23, 1'b1);

    run_muldiv("divu_zero", OP_DIVU, 32'd10, 32'd0, DIV_STALLS, 0);
    expect_out(5'd24, 1'b1, 32'hFFFF_FFFF, 1'b0);
    issue(SEL_MOVE, OP_MFLO, 32'h0, 32'h0, 5'd24, 1'b1);
    expect_out(5'd25, 1'b1, 32'h0000_000A, 1'b0);
    issue(SEL_MOVE, OP_MFHI, 32'h0, 32'h0, 5'd25, 1'b1);

    run_muldiv("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_STALLS, 0);
    expect_out(5'd26, 1'b1, 32'hFFFF_FFFE, 1'b0);
    issue(SEL_MOVE, OP_MFHI, 32'h0, 32'h0, 5'd26, 1'b1);
    expect_out(5'd27, 1'b1, 32'h0000_0001, 1'b0);
    issue(SEL_MOVE, OP_MFLO, 32'h0, 32'h0, 5'd27, 1'b1);

    // Flush on BUSY cycle 10 leaves HI/LO at the MULTU result
    run_muldiv("flush", FLUSH_OP, 32'd5, 32'd5, 0, 10);
    expect_out(5'd28, 1'b1, 32'hFFFF_FFFE, 1'b0);
    issue(SEL_MOVE, OP_MFHI, 32'h0, 32'h0, 5'd28, 1'b1);
    expect_out(5'd29, 1'b1, 32'h0000_0001, 1'b0);
    issue(SEL_MOVE, OP_MFLO, 32'h0, 32'h0, 5'd29, 1'b1);

    // MTHI/MTLO round trip
    issue(SEL_MOVE, OP_MTHI, 32'hCAFE_0001, 32'h0, 5'd0, 1'b0);
    issue(SEL_MOVE, OP_MTLO, 32'h0000_BEEF, 32'h0, 5'd0, 1'b0);
    expect_out(5'd30, 1'b1, 32'hCAFE_0001, 1'b0);
    issue(SEL_MOVE, OP_MFHI, 32'h0, 32'h0, 5'd30, 1'b1);
    expect_out(5'd31, 1'b1, 32'h0000_BEEF, 1'b0);
    issue(SEL_MOVE, OP_MFLO, 32'h0, 32'h0, 5'd31, 1'b1);

    idle(4);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
